// File: rtl/ex_muldiv_ctrl_if.sv
// ex_muldiv_ctrl_if: bundles every non-clock signal of the RV32M execute sequencer.
//   req_*      : decoded M-ext op from issue (valid/ready handshake)
//   flush      : pipeline kill
//   alu_*      : operand/op drive to the shared alu and its result/busy return
//   rsp_*      : final rd value and tag to writeback (valid/ready handshake)
//   err        : one-cycle pulse when the divider wait times out
// Modports: slave = the sequencer, master = its environment (issue, alu, writeback).
interface ex_muldiv_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [3:0]  alu_op;
    logic [63:0] alu_result;
    logic        alu_busy;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        err;

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, flush,
        input  alu_result, alu_busy, rsp_ready,
        output req_ready, alu_data1, alu_data2, alu_op, rsp_valid, rsp_data, rsp_rd, err
    );

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, flush,
        output alu_result, alu_busy, rsp_ready,
        input  req_ready, alu_data1, alu_data2, alu_op, rsp_valid, rsp_data, rsp_rd, err
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: execute-stage sequencer for RV32M ops in front of the shared alu.
// Accepts one op, drives the alu, waits out the multi-cycle divider, applies the RISC-V
// result fix-ups (high half, MULHSU correction, div/rem sign restore, div-by-zero and
// signed-overflow bypass) and presents the result to writeback.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    ex_muldiv_ctrl_if.slave (request, alu, response, flush, err)
// Parameters:
//   XLEN      operand width; only 32 is supported (alu result is 64 bits)
//   WAIT_MAX  cycles the divider may stay busy before err pulses and the op is abandoned
// alu op codes: 0 nop, 1 mul_s, 2 mul_u, 3 div_s, 4 div_u, 5 rem_s, 6 rem_u.
module ex_muldiv_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WAIT_MAX = 127
) (
    input logic             clk,
    input logic             rst_n,
    ex_muldiv_ctrl_if.slave bus
);
    localparam int unsigned WdogW = $clog2(WAIT_MAX + 1);

    localparam logic [3:0] AluNop  = 4'd0;
    localparam logic [3:0] AluMulS = 4'd1;
    localparam logic [3:0] AluMulU = 4'd2;
    localparam logic [3:0] AluDivS = 4'd3;
    localparam logic [3:0] AluDivU = 4'd4;
    localparam logic [3:0] AluRemS = 4'd5;
    localparam logic [3:0] AluRemU = 4'd6;

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [4:0]        rd_q, rd_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;

    logic [3:0]        alu_op;
    logic [3:0]        op_alu;
    logic              err;
    logic [XLEN-1:0]   fixed;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;
    logic              div_zero;
    logic              div_ovf;

    // funct3 bit 2 = divide class, bit 1 = remainder, bit 0 = unsigned
    assign div_zero = (bus.req_rs2 == '0);
    assign div_ovf  = (bus.req_rs1 == IntMin) && (bus.req_rs2 == '1);

    always_comb begin
        op_alu = AluNop;
        unique case (op_q)
            3'd0, 3'd1: op_alu = AluMulS;
            3'd2, 3'd3: op_alu = AluMulU;
            3'd4:       op_alu = AluDivS;
            3'd5:       op_alu = AluDivU;
            3'd6:       op_alu = AluRemS;
            3'd7:       op_alu = AluRemU;
        endcase
    end

    assign res_hi = bus.alu_result[63:32];
    assign res_lo = bus.alu_result[31:0];

    // MULHSU runs as unsigned x unsigned; a negative rs1 over-counts by rs2 << 32.
    // Signed div/rem come back from the alu as magnitudes.
    always_comb begin
        fixed = res_lo;
        unique case (op_q)
            3'd0:       fixed = res_lo;
            3'd1, 3'd3: fixed = res_hi;
            3'd2:       fixed = res_hi - (rs1_q[XLEN-1] ? rs2_q : '0);
            3'd4:       fixed = (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]) ? -res_lo : res_lo;
            3'd6:       fixed = rs1_q[XLEN-1] ? -res_lo : res_lo;
            3'd5, 3'd7: fixed = res_lo;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        data_d  = data_q;
        wdog_d  = wdog_q;
        alu_op  = AluNop;
        err     = 1'b0;

        if (bus.flush) begin
            // divider cannot abort, so a busy alu must be waited out before reuse
            state_d = bus.alu_busy ? StDrain : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        op_d  = bus.req_op;
                        rs1_d = bus.req_rs1;
                        rs2_d = bus.req_rs2;
                        rd_d  = bus.req_rd;
                        if (bus.req_op[2] && div_zero) begin
                            data_d  = bus.req_op[1] ? bus.req_rs1 : '1;
                            state_d = StResp;
                        end else if (bus.req_op[2] && !bus.req_op[0] && div_ovf) begin
                            data_d  = bus.req_op[1] ? '0 : IntMin;
                            state_d = StResp;
                        end else begin
                            state_d = StIssue;
                        end
                    end
                end
                StIssue: begin
                    alu_op = op_alu;
                    if (!op_q[2]) begin
                        data_d  = fixed;
                        state_d = StResp;
                    end else begin
                        wdog_d  = '0;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    alu_op = op_alu;
                    if (!bus.alu_busy) begin
                        data_d  = fixed;
                        state_d = StResp;
                    end else if (wdog_q == WdogW'(WAIT_MAX)) begin
                        err     = 1'b1;
                        state_d = StDrain;
                    end else begin
                        wdog_d = wdog_q + WdogW'(1);
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_d = StIdle;
                    end
                end
                StDrain: begin
                    if (!bus.alu_busy) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle) && !bus.flush;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_rd    = rd_q;
    assign bus.alu_data1 = rs1_q;
    assign bus.alu_data2 = rs2_q;
    assign bus.alu_op    = alu_op;
    assign bus.err       = err;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: behavioural alu (combinational multiply, multi-cycle
// magnitude divider), scoreboard queue filled at accept and drained by a monitor at
// each writeback handshake, directed corner cases followed by randomized ops.
module tb_ex_muldiv_ctrl;
    localparam logic [3:0] ANop  = 4'd0;
    localparam logic [3:0] AMulS = 4'd1;
    localparam logic [3:0] AMulU = 4'd2;
    localparam logic [3:0] ADivS = 4'd3;
    localparam logic [3:0] ADivU = 4'd4;
    localparam logic [3:0] ARemS = 4'd5;
    localparam logic [3:0] ARemU = 4'd6;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_ctrl_if bus ();

    ex_muldiv_ctrl #(.XLEN(32), .WAIT_MAX(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   ready_mode = 0;
    int   div_lat = 4;
    int   alu_starts = 0;
    int   exp_starts = 0;
    int   err_cnt = 0;
    int   nonnop_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- reference model: RV32M semantics from plain arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // ---------------- alu model
    function automatic bit is_div_op(input logic [3:0] op);
        return (op == ADivS) || (op == ADivU) || (op == ARemS) || (op == ARemU);
    endfunction

    function automatic logic [31:0] alu_div(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] ma, mb;
        bit          sgn;
        sgn = (op == ADivS) || (op == ARemS);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (mb == 0) return 32'hFFFF_FFFF;
        return ((op == ADivS) || (op == ADivU)) ? ma / mb : ma % mb;
    endfunction

    int          alu_st;   // 0 idle, 1 running, 2 result just produced
    int          alu_cnt;
    logic [31:0] alu_div_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_st      <= 0;
            alu_cnt     <= 0;
            alu_div_res <= '0;
        end else begin
            case (alu_st)
                0: if (is_div_op(bus.alu_op)) begin
                    alu_st      <= 1;
                    alu_cnt     <= div_lat;
                    alu_div_res <= alu_div(bus.alu_op, bus.alu_data1, bus.alu_data2);
                end
                1: if (alu_cnt <= 1) alu_st <= 2; else alu_cnt <= alu_cnt - 1;
                default: alu_st <= 0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n && alu_st == 0 && is_div_op(bus.alu_op)) alu_starts++;
    end

    assign bus.alu_busy = (alu_st == 1);

    always_comb begin
        bus.alu_result = {32'b0, alu_div_res};
        if (bus.alu_op == AMulS)
            bus.alu_result = longint'($signed(bus.alu_data1)) * longint'($signed(bus.alu_data2));
        else if (bus.alu_op == AMulU)
            bus.alu_result = {32'b0, bus.alu_data1} * {32'b0, bus.alu_data2};
    end

    // ---------------- writeback ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = 1'($urandom_range(0, 1));
            default: bus.rsp_ready = 1'b0;
        endcase
    end

    // ---------------- monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.err) err_cnt++;
        if (bus.alu_op != ANop) nonnop_cnt++;
        if (rst_n && bus.rsp_valid && bus.rsp_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got data=%0h rd=%0d required no response",
                         bus.rsp_data, bus.rsp_rd);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                check("rsp_rd", 64'(bus.rsp_rd), 64'(e.rd));
                check("alu_op_nop_in_resp", 64'(bus.alu_op), 64'(ANop));
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit want_rsp);
        bit acc;
        bit special;
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_rd    = rd;
        acc = 1'b0;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_accept: got no accept required accept within 2000 cycles");
        end else begin
            special = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            if (op[2] && !special) exp_starts++;
            if (want_rsp) begin
                e.data = ref_model(op, a, b);
                e.rd   = rd;
                exp_q.push_back(e);
            end
        end
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.rsp_valid && bus.req_ready;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          cyc;
        int          nn0;
        int          e0;
        int          bad_rdy;
        bit          flag;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;

        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_rd", 64'(bus.rsp_rd), 64'd0);
        check("rst_alu_data1", 64'(bus.alu_data1), 64'd0);
        check("rst_alu_data2", 64'(bus.alu_data2), 64'd0);
        check("rst_alu_op", 64'(bus.alu_op), 64'(ANop));
        check("rst_err", 64'(bus.err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MULH and its accept-to-valid latency
        send(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5'd1, 1'b1);
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            @(posedge clk);
            cyc++;
        end
        check("mulh_latency", 64'(cyc), 64'd2);
        wait_drain();

        send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
        send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
        wait_drain();

        div_lat = 6;
        send(3'd4, -32'sd7, 32'd2, 5'd4, 1'b1);
        send(3'd6, -32'sd7, 32'd2, 5'd5, 1'b1);
        wait_drain();

        // divide by zero never touches the alu
        nn0 = nonnop_cnt;
        send(3'd5, 32'h1234, 32'd0, 5'd6, 1'b1);
        send(3'd7, 32'h1234, 32'd0, 5'd7, 1'b1);
        wait_drain();
        check("divz_alu_nop_cycles", 64'(nonnop_cnt - nn0), 64'd0);

        // signed overflow with writeback stalled
        ready_mode = 2;
        send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1);
        flag = 1'b0;
        for (int i = 0; i < 20 && !flag; i++) begin
            @(negedge clk);
            flag = bus.rsp_valid;
        end
        check("ovf_rsp_valid_seen", 64'(flag), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_data", 64'(bus.rsp_data), 64'h8000_0000);
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            @(negedge clk);
        end
        ready_mode = 0;
        wait_drain();

        // flush ten cycles into a divide
        div_lat = 40;
        send(3'd4, 32'd100, 32'd7, 5'd10, 1'b0);
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bad_rdy = 0;
        flag = 1'b0;
        for (int i = 0; i < 100 && !flag; i++) begin
            @(negedge clk);
            if (!bus.alu_busy) flag = 1'b1;
            else if (bus.req_ready || bus.rsp_valid) bad_rdy++;
        end
        check("flush_ready_low_while_busy", 64'(bad_rdy), 64'd0);
        check("flush_busy_fell", 64'(flag), 64'd1);
        @(negedge clk);
        check("flush_ready_back", 64'(bus.req_ready), 64'd1);
        wait_drain();

        // divider hang: watchdog pulse, then return once the alu frees up
        div_lat = 250;
        e0 = err_cnt;
        send(3'd5, 32'd1000, 32'd3, 5'd11, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 600 && !flag; i++) begin
            @(negedge clk);
            flag = bus.req_ready && !bus.alu_busy;
        end
        check("wdog_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("wdog_back_idle", 64'(flag), 64'd1);
        wait_drain();

        // async reset mid-divide
        div_lat = 40;
        send(3'd4, 32'd100, 32'd3, 5'd12, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(bus.req_ready), 64'd1);
        check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("arst_alu_op", 64'(bus.alu_op), 64'(ANop));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // randomized ops with random writeback backpressure
        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel <= 3) begin
                a = 32'($urandom_range(0, 40)) - 32'd20;
                b = 32'($urandom_range(0, 40)) - 32'd20;
            end
            div_lat = $urandom_range(1, 12);
            send(op, a, b, 5'($urandom_range(0, 31)), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 0;
        wait_drain();

        check("alu_div_starts", 64'(alu_starts), 64'(exp_starts));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
